md_unit: RTL

- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Executes mult, multu, div, divu, mthi and mtlo, and holds the HI/LO registers.
- Its read port supplies the MD value that the EX/MEM pipeline register selects when WDSel=MD (mfhi/mflo).
- Exposes busy/hazard status so the stall controller can hold MD-class instructions in ID while an operation is in flight.

---
 rtl/md_unit_pkg.sv | 29 ++
 rtl/md_unit_calc.sv | 51 +++++
 rtl/md_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings, HI/LO
// read selects, default latencies, FSM states and a magnitude helper.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam logic RD_LO = 1'b0;
    localparam logic RD_HI = 1'b1;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } md_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_unit_calc.sv
// Combinational MD arithmetic: 64-bit product, or {remainder, quotient} for
// divides, plus a divide-by-zero flag. No state, no latency.
module md_unit_calc
    import md_unit_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  md_op,
    output logic [63:0] result,
    output logic        div_zero
);

    md_op_e      op;
    logic        is_signed;
    logic        is_div;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign op = md_op_e'(md_op);

    always_comb begin
        is_signed = (op == MD_MULT) || (op == MD_DIV);
        is_div    = (op == MD_DIV) || (op == MD_DIVU);

        // Low 64 bits of the extended product are correct for both signednesses.
        ext_a = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        ext_b = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        prod  = ext_a * ext_b;

        // Divide on magnitudes so 0x80000000 / -1 wraps back to 0x80000000.
        mag_a    = is_signed ? abs32(a) : a;
        mag_b    = is_signed ? abs32(b) : b;
        div_zero = (b == 32'd0);
        divisor  = div_zero ? 32'd1 : mag_b;
        q_mag    = mag_a / divisor;
        r_mag    = mag_a % divisor;
        quo      = (is_signed && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
        rem      = (is_signed && a[31]) ? (~r_mag + 32'd1) : r_mag;

        result = is_div ? {rem, quo} : prod;
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit holding HI/LO; results land in shadow regs and
// commit after MULT_CYCLES/DIV_CYCLES while busy stalls further MD instructions.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        rd_sel,
    output logic [31:0] md_out,
    output logic        busy,
    output logic        md_hazard
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [31:0]        hi, hi_n, lo, lo_n;
    logic [31:0]        sh_hi, sh_hi_n, sh_lo, sh_lo_n;
    logic               sh_dz, sh_dz_n;
    logic [63:0]        calc_res;
    logic               calc_dz;

    md_unit_calc u_calc (
        .a        (a),
        .b        (b),
        .md_op    (md_op),
        .result   (calc_res),
        .div_zero (calc_dz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            sh_hi <= '0;
            sh_lo <= '0;
            sh_dz <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hi    <= hi_n;
            lo    <= lo_n;
            sh_hi <= sh_hi_n;
            sh_lo <= sh_lo_n;
            sh_dz <= sh_dz_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hi_n    = hi;
        lo_n    = lo;
        sh_hi_n = sh_hi;
        sh_lo_n = sh_lo;
        sh_dz_n = sh_dz;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (md_op_e'(md_op))
                        MD_MULT, MD_MULTU: begin
                            sh_hi_n = calc_res[63:32];
                            sh_lo_n = calc_res[31:0];
                            sh_dz_n = 1'b0;
                            cnt_n   = CNT_W'(MULT_CYCLES);
                            state_n = ST_BUSY;
                        end
                        MD_DIV, MD_DIVU: begin
                            sh_hi_n = calc_res[63:32];
                            sh_lo_n = calc_res[31:0];
                            sh_dz_n = calc_dz;
                            cnt_n   = CNT_W'(DIV_CYCLES);
                            state_n = ST_BUSY;
                        end
                        MD_MTHI: hi_n = a;
                        MD_MTLO: lo_n = a;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                if (cnt > CNT_W'(1)) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    // A divide by zero still runs the full latency but leaves HI/LO alone.
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                    if (!sh_dz) begin
                        hi_n = sh_hi;
                        lo_n = sh_lo;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy      = (state == ST_BUSY);
    assign md_hazard = start | busy;
    assign md_out    = (rd_sel == RD_HI) ? hi : lo;

endmodule
